trap_ctrl: RTL



---
 rtl/trap_ctrl_if.sv | 44 ++++
 rtl/trap_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-file side bundle of the trap sequencer; master = pipeline and CSR file, slave = trap_ctrl.
// Carries event requests, live CSR values, CSR write strobes/values and the PC redirect.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            mret_req;
  logic [XLEN-1:0] int_pc;
  logic            irq_mei;
  logic            irq_msi;
  logic            irq_mti;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            csr_w;

  logic            trap;
  logic            mret;
  logic [XLEN-1:0] mepc_in;
  logic [XLEN-1:0] mcause_in;
  logic [XLEN-1:0] mtval_in;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval, mret_req, int_pc,
           irq_mei, irq_msi, irq_mti, mstatus, mie, mtvec, mepc, csr_w,
    input  trap, mret, mepc_in, mcause_in, mtval_in, flush,
           redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval, mret_req, int_pc,
           irq_mei, irq_msi, irq_mti, mstatus, mie, mtvec, mepc, csr_w,
    output trap, mret, mepc_in, mcause_in, mtval_in, flush,
           redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: exceptions/mret/interrupts -> CSR trap/mret strobe, flush, one redirect (vectored mode: TRAP_VECTORED_EN).
// Latency: strobe one cycle after the sampling edge, redirect one cycle later; +1 cycle per cycle csr_w is held.
// Backpressure: csr_w stalls the strobe in TRAP/RET; requests outside IDLE are ignored and re-sampled in IDLE.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRAP  = 2'd1;
  localparam logic [1:0] RET   = 2'd2;
  localparam logic [1:0] REDIR = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] cause;
  logic [XLEN-1:0] tval;
  logic [XLEN-1:0] target;

  logic [2:0]      ip;
  logic            int_any;
  logic [3:0]      int_code;
  logic [XLEN-1:0] int_cause;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] ret_target;

  // Pending vector ordered {MEI, MSI, MTI}, globally masked by mstatus.MIE.
  assign ip        = {bus.irq_mei & bus.mie[11],
                      bus.irq_msi & bus.mie[3],
                      bus.irq_mti & bus.mie[7]} & {3{bus.mstatus[3]}};
  assign int_any   = |ip;

  always_comb begin
    int_code = 4'd7;
    if (ip[2]) begin
      int_code = 4'd11;
    end else if (ip[1]) begin
      int_code = 4'd3;
    end
  end

  assign int_cause  = {1'b1, {(XLEN-5){1'b0}}, int_code};
  assign exc_cause  = {{(XLEN-4){1'b0}}, bus.exc_code};
  assign base       = {bus.mtvec[XLEN-1:2], 2'b00};
  assign ret_target = {bus.mepc[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Only interrupts vector; exceptions always land on the base address.
  always_comb begin
    trap_vector = base;
    if (bus.mtvec[1:0] == 2'b01 && cause[XLEN-1]) begin
      trap_vector = base + XLEN'({cause[3:0], 2'b00});
    end
  end
`else
  assign trap_vector = base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      epc    <= '0;
      cause  <= '0;
      tval   <= '0;
      target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.exc_valid) begin
            epc   <= bus.exc_pc;
            cause <= exc_cause;
            tval  <= bus.exc_tval;
            state <= TRAP;
          end else if (bus.mret_req) begin
            state <= RET;
          end else if (int_any) begin
            epc   <= bus.int_pc;
            cause <= int_cause;
            tval  <= '0;
            state <= TRAP;
          end
        end
        TRAP: begin
          if (!bus.csr_w) begin
            target <= trap_vector;
            state  <= REDIR;
          end
        end
        RET: begin
          if (!bus.csr_w) begin
            target <= ret_target;
            state  <= REDIR;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  always_comb begin
    bus.trap           = 1'b0;
    bus.mret           = 1'b0;
    bus.mepc_in        = '0;
    bus.mcause_in      = '0;
    bus.mtval_in       = '0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (state)
      TRAP: begin
        bus.trap      = !bus.csr_w;
        bus.mepc_in   = epc;
        bus.mcause_in = cause;
        bus.mtval_in  = tval;
        bus.flush     = 1'b1;
      end
      RET: begin
        bus.mret      = !bus.csr_w;
        bus.mepc_in   = bus.mepc;
        bus.mcause_in = cause;
        bus.mtval_in  = tval;
        bus.flush     = 1'b1;
      end
      REDIR: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {target[XLEN-1:2], 2'b00};
      end
      default: begin
      end
    endcase
  end

  assign bus.busy = (state != IDLE);

  logic unused_bits;
  assign unused_bits = ^{bus.mstatus, bus.mie, bus.mtvec[1:0], bus.mepc[1:0], target[1:0]};

endmodule
